// File: rtl/udsp_data_mem.sv
// uDSP data memory: two core read ports, one core write port and a handshaked host port.
// Optional power-up clear sweep is enabled by defining UDSP_DMEM_INIT_CLEAR_EN.
module udsp_data_mem #(
  parameter int DAW = 10,
  parameter int DWW = 36
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [DAW-1:0] i_addrA,
  output logic [DWW-1:0] o_dataA,
  input  logic [DAW-1:0] i_addrB,
  output logic [DWW-1:0] o_dataB,
  input  logic [DAW-1:0] i_addrW,
  input  logic [DWW-1:0] i_dataW,
  input  logic           i_writeEn,
  input  logic           i_host_req,
  input  logic           i_host_we,
  input  logic [DAW-1:0] i_host_addr,
  input  logic [DWW-1:0] i_host_wdata,
  output logic           o_host_ack,
  output logic [DWW-1:0] o_host_rdata,
  output logic           o_init_busy
);

  localparam int DEPTH = 1 << DAW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  logic [DWW-1:0] r_mem [DEPTH];

  logic [DAW-1:0] r_addrA;
  logic [DAW-1:0] r_addrB;
  logic [1:0]     r_state;
  logic           r_host_ack;
  logic [DAW-1:0] r_host_addr;
  logic [DWW-1:0] r_host_wdata;
  logic [DWW-1:0] r_host_rdata;

  logic [1:0]     w_state_nxt;
  logic           w_host_commit;
  logic           w_init_busy;
  logic           w_user_we;
  logic [DAW-1:0] w_user_addr;
  logic [DWW-1:0] w_user_wdata;
  logic           w_mem_we;
  logic [DAW-1:0] w_mem_addr;
  logic [DWW-1:0] w_mem_wdata;

`ifdef UDSP_DMEM_INIT_CLEAR_EN
  logic           r_init_busy;
  logic [DAW-1:0] r_init_addr;

  // Clear sweep: one word per cycle from address 0, restarted by every reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_init_busy <= 1'b1;
      r_init_addr <= {DAW{1'b0}};
    end else if (r_init_busy) begin
      r_init_addr <= r_init_addr + {{(DAW-1){1'b0}}, 1'b1};
      if (r_init_addr == {DAW{1'b1}}) begin
        r_init_busy <= 1'b0;
      end else begin
        r_init_busy <= 1'b1;
      end
    end else begin
      r_init_busy <= 1'b0;
      r_init_addr <= r_init_addr;
    end
  end

  assign w_init_busy = r_init_busy;
`else
  assign w_init_busy = 1'b0;
`endif

  // A host write only commits on an edge the core leaves free.
  assign w_host_commit = (r_state == ST_WAIT) && !i_writeEn;

  // Arbitrate the single storage write port: core first, deferred host write second.
  always_comb begin
    w_user_we    = 1'b0;
    w_user_addr  = i_addrW;
    w_user_wdata = i_dataW;
    if (i_writeEn) begin
      w_user_we = 1'b1;
    end else if (w_host_commit) begin
      w_user_we    = 1'b1;
      w_user_addr  = r_host_addr;
      w_user_wdata = r_host_wdata;
    end else begin
      w_user_we = 1'b0;
    end
  end

  // The clear sweep, when present, overrides every other writer.
  always_comb begin
    w_mem_we    = w_user_we;
    w_mem_addr  = w_user_addr;
    w_mem_wdata = w_user_wdata;
`ifdef UDSP_DMEM_INIT_CLEAR_EN
    if (r_init_busy) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_init_addr;
      w_mem_wdata = {DWW{1'b0}};
    end else begin
      w_mem_we    = w_user_we;
    end
`endif
  end

  // Storage write; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Core read addresses; reading storage through them gives write-first data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addrA <= {DAW{1'b0}};
      r_addrB <= {DAW{1'b0}};
    end else begin
      r_addrA <= i_addrA;
      r_addrB <= i_addrB;
    end
  end

  assign o_dataA = r_mem[r_addrA];
  assign o_dataB = r_mem[r_addrB];

  // Host FSM next-state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_host_req && !w_init_busy) begin
          w_state_nxt = i_host_we ? ST_WAIT : ST_RD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!i_writeEn) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RD:   w_state_nxt = ST_ACK;
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Host FSM state, request capture, third read path and ack pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_host_ack   <= 1'b0;
      r_host_addr  <= {DAW{1'b0}};
      r_host_wdata <= {DWW{1'b0}};
      r_host_rdata <= {DWW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_host_ack <= (w_state_nxt == ST_ACK);
      if ((r_state == ST_IDLE) && (w_state_nxt != ST_IDLE)) begin
        r_host_addr  <= i_host_addr;
        r_host_wdata <= i_host_wdata;
      end else begin
        r_host_addr  <= r_host_addr;
        r_host_wdata <= r_host_wdata;
      end
      if (r_state == ST_RD) begin
        r_host_rdata <= r_mem[r_host_addr];
      end else begin
        r_host_rdata <= r_host_rdata;
      end
    end
  end

  assign o_host_ack   = r_host_ack;
  assign o_host_rdata = r_host_rdata;
  assign o_init_busy  = w_init_busy;

endmodule

// File: doc/udsp_data_mem.md
Name: udsp_data_mem

Overview:
- Data-memory responder serving the uDSP core's data ports: read port A, read port B and write port W.
- Also gives a host controller handshaked read/write access to the same storage, for audio sample I/O and coefficient loading while the core runs.
- Storage is 2^DAW words of DWW bits, addressed as 3-bit segment plus 7-bit word.
- Sits between the uDSP core and the host/bus bridge.

Parameters:
- DAW, 10, address width (segment + word).
- DWW, 36, data word width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- addrA  in  DAW  core read address A; sampled at posedge.
- dataA  out  DWW  read data A; valid one cycle after addrA.
- addrB  in  DAW  core read address B; sampled at posedge.
- dataB  out  DWW  read data B; valid one cycle after addrB.
- addrW  in  DAW  core write address.
- dataW  in  DWW  core write data.
- writeEn  in  1  core write strobe; the write commits at posedge.
- host_req  in  1  host request; held until host_ack.
- host_we  in  1  host request is a write; stable while host_req is high.
- host_addr  in  DAW  host address; stable while host_req is high.
- host_wdata  in  DWW  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DWW  host read data; valid in the host_ack cycle.
- init_busy  out  1  clear sweep in progress (optional feature).

Behaviour:
- Clock and reset: clk, with reset asynchronous and active-high. Reset clears FSM state, host_ack and host_rdata. It also clears the registered A/B addresses to 0, so dataA and dataB show mem[0]. Storage contents are not cleared, except under the optional feature.
- Core read ports:
  - addrA and addrB are registered at posedge; dataA = mem[addrA_q], dataB = mem[addrB_q]. Latency is one clock. This matches the core presenting addresses in fetch and capturing data at the read/execute boundary.
  - Write-first: if a write commits on the same edge that registers a read address equal to the write address, the read port returns the newly written data.
- Core write port: writeEn=1 writes dataW to addrW at posedge. It has absolute priority and is never stalled.
- Host FSM states: IDLE, WAIT, RD, ACK.
  - IDLE: on host_req, go to WAIT for a write (host_we=1) or RD for a read.
  - WAIT: commit the host write on the first edge with writeEn=0, then go to ACK. If writeEn stays high, remain in WAIT indefinitely.
  - RD: host read uses a dedicated third read path. The address is registered on entry and never contends with the core. Go to ACK next cycle.
  - ACK: host_ack=1 for exactly one cycle. host_rdata = read data for reads, unchanged for writes. Return to IDLE.
  - A request still high in IDLE after ACK is treated as a new request.
  - Best-case latency from host_req to host_ack: write 2 cycles, read 2 cycles.
- Simultaneous events:
  - A host write and a core write to the same address cannot commit together, because the host write defers.
  - A host read of an address written by the core on the RD-entry edge returns the new data (write-first).
- Reset mid-transaction: return to IDLE and drop any uncommitted host write. No ack is issued; the host must re-request.
- Address wrap-around: none. All 2^DAW addresses are valid, and upper segment bits are not masked.

Optional Feature:
- Macro: UDSP_DMEM_INIT_CLEAR_EN.
- Enabled:
  - After reset deassertion, a 2^DAW-cycle sweep writes 0 to addresses 0..2^DAW-1, one per cycle, with init_busy=1.
  - During the sweep, core writes are ignored, reads return swept-or-old data, and host requests wait in IDLE.
  - init_busy drops the cycle after address 2^DAW-1 is written.
  - Reset during the sweep restarts it at address 0.
- Disabled: init_busy is tied 0, no sweep, and memory powers up undefined.

Test Plan:
- Core read latency: write 0x123456789 to addr 0x005 via W, then addrA=0x005 the next cycle -> dataA=0x123456789 one cycle later; dataB unaffected.
- Write-first bypass: writeEn=1, addrW=0x0A0, dataW=0xFFFFFFFFF, and addrB=0x0A0 on the same edge (old value 0x1) -> dataB=0xFFFFFFFFF the next cycle.
- Host write contention: writeEn held high 5 cycles, host_req/host_we to addr 0x380 with data 0x42 -> host_ack exactly 1 cycle after writeEn falls; a subsequent read of 0x380 returns 0x42, and all 5 core writes intact.
- Host read: host_req read of 0x3FF holding 0xABC -> host_ack pulses for one cycle 2 cycles after req, with host_rdata=0xABC; concurrent core A/B reads unaffected.
- Reset mid-transaction: reset asserted while in WAIT -> host_ack never pulses, host_rdata=0, target word unchanged.
- UDSP_DMEM_INIT_CLEAR_EN: preload nonzero values, then reset -> init_busy high for 1024 cycles, all words read 0 afterward, and a host request issued during the sweep is acked only after init_busy falls.
